muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_datapath.sv | 78 +++++++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide on operand magnitudes, one bit per step.
// Latency: XLEN steps after load; final_res reflects the value the current step produces.
// Backpressure: none; the controller decides when to load and step.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic            neg_main,
  input  logic            neg_rem,
  input  logic            want_hi,
  input  logic [XLEN-1:0] mag_a,
  input  logic [XLEN-1:0] mag_b,
  output logic [XLEN-1:0] final_res
);

  // hi_q: running product high word / partial remainder.
  // lo_q: multiplier bits still to consume / dividend bits shifting into quotient.
  logic [XLEN-1:0]   hi_q, lo_q, b_q;
  logic              mode_q;
  logic [XLEN-1:0]   hi_d, lo_d;
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  // One iteration of the add/subtract step plus sign correction of the value it yields.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (mode_q) begin
      // Restoring divide: keep the trial difference only when it did not borrow.
      if (!diff[XLEN]) begin
        hi_d = diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = shifted[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      // Shift-add: the carry out of the add drops into the top of the high word.
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
    prod = {hi_d, lo_d};
    if (neg_main) prod = -prod;
    quo = neg_main ? -lo_d : lo_d;
    rem = neg_rem ? -hi_d : hi_d;
    if (mode_q) final_res = want_hi ? rem : quo;
    else        final_res = want_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  // Accumulator and shift registers: cleared/loaded on accept, advanced once per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= mag_a;
      b_q    <= mag_b;
      mode_q <= div_mode;
    end else if (step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with divide special-case fast paths.
// Latency: result in the XLEN+1th cycle after accept (1 for divide-by-zero / overflow).
// Backpressure: in_ready only in IDLE; result held with out_valid until out_ready; flush kills.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            neg_main_q, neg_rem_q, want_hi_q;
  logic            dp_load, dp_step;
  logic [XLEN-1:0] dp_res;

  logic            a_signed, b_signed, sign_a, sign_b;
  logic            is_div, is_rem, want_hi, fast_zero, fast_ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_val;
  logic            accept, finish;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid & in_ready & ~flush;
  assign finish   = (state_q == BUSY) & (cnt_q == '0) & ~flush;

  assign a_signed  = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign b_signed  = funct3 inside {F3_MULH, F3_DIV, F3_REM};
  assign is_div    = funct3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  assign is_rem    = funct3 inside {F3_REM, F3_REMU};
  assign want_hi   = funct3 inside {F3_MULH, F3_MULHSU, F3_MULHU, F3_REM, F3_REMU};
  assign sign_a    = a_signed & op_a[XLEN-1];
  assign sign_b    = b_signed & op_b[XLEN-1];
  assign mag_a     = sign_a ? -op_a : op_a;
  assign mag_b     = sign_b ? -op_b : op_b;
  assign fast_zero = is_div & (op_b == '0);
  assign fast_ovf  = (funct3 inside {F3_DIV, F3_REM}) & (op_a == MIN_VAL) & (op_b == '1);
  assign fast      = fast_zero | fast_ovf;
  assign fast_val  = fast_zero ? (is_rem ? op_a : '1) : (is_rem ? '0 : MIN_VAL);

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (dp_load),
    .step      (dp_step),
    .div_mode  (is_div),
    .neg_main  (neg_main_q),
    .neg_rem   (neg_rem_q),
    .want_hi   (want_hi_q),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .final_res (dp_res)
  );

  // Next-state and datapath control; flush overrides everything.
  always_comb begin
    state_d = state_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        dp_load = 1'b1;
        state_d = fast ? DONE : BUSY;
      end
      BUSY: begin
        dp_step = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      dp_load = 1'b0;
      dp_step = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Iteration counter and the sign/word-select decisions captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_hi_q  <= 1'b0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q      <= CW'(XLEN-1);
      neg_main_q <= sign_a ^ sign_b;
      neg_rem_q  <= sign_a;
      want_hi_q  <= want_hi;
    end else if (dp_step && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Registered result and out_valid: set by fast path or final iteration, cleared on handoff/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else if (accept && fast) begin
      result    <= fast_val;
      out_valid <= 1'b1;
    end else if (finish) begin
      result    <= dp_res;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
